// File: rtl/register_32_4_unloader_pkg.sv
// Shared encodings and sizes for the 4-word parallel-in / serial-out unloader.
package register_32_4_unloader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int          WORD_WIDTH = 32;
    localparam logic [1:0]  LAST_IDX   = 2'd3;

endpackage : register_32_4_unloader_pkg

// File: rtl/register_32_4_unloader_if.sv
// Frame-in / word-out stream bundle; slave is the unloader side, master the producer/consumer side.
interface register_32_4_unloader_if
    import register_32_4_unloader_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic [WIDTH-1:0] in_3;
    logic [WIDTH-1:0] in_4;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_index;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_1, in_2, in_3, in_4, out_ready,
        input  in_ready, out_data, out_valid, out_index, out_last, busy
    );

    modport slave (
        input  in_valid, in_1, in_2, in_3, in_4, out_ready,
        output in_ready, out_data, out_valid, out_index, out_last, busy
    );

endinterface : register_32_4_unloader_if

// File: rtl/register_32_4_unloader_word_select_4.sv
// 4:1 word multiplexer; output is forced to zero whenever no word is being offered.
module register_32_4_unloader_word_select_4
    import register_32_4_unloader_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] word_0,
    input  logic [WIDTH-1:0] word_1,
    input  logic [WIDTH-1:0] word_2,
    input  logic [WIDTH-1:0] word_3,
    input  logic [1:0]       index,
    input  logic             valid,
    output logic [WIDTH-1:0] data
);

    always_comb begin
        data = '0;
        if (valid) begin
            case (index)
                2'd0:    data = word_0;
                2'd1:    data = word_1;
                2'd2:    data = word_2;
                default: data = word_3;
            endcase
        end
    end

endmodule : register_32_4_unloader_word_select_4

// File: rtl/register_32_4_unloader.sv
// Accepts a 4-word frame in one handshake, then streams the words out in index order.
module register_32_4_unloader
    import register_32_4_unloader_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    register_32_4_unloader_if.slave  bus
);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             last_q;
    logic [1:0]       index_q;
    logic [WIDTH-1:0] word_0;
    logic [WIDTH-1:0] word_1;
    logic [WIDTH-1:0] word_2;
    logic [WIDTH-1:0] word_3;
    logic [WIDTH-1:0] out_data;
    logic             accept;

    // in_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
    assign accept = bus.in_valid & in_ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
            index_q     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state       <= SEND;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        index_q     <= 2'd0;
                        last_q      <= 1'b0;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (index_q == LAST_IDX) begin
                            state       <= IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            index_q     <= 2'd0;
                            last_q      <= 1'b0;
                        end else begin
                            index_q <= index_q + 2'd1;
                            last_q  <= ((index_q + 2'd1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Frame words are captured only on the accept handshake and frozen for the whole frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_0 <= '0;
            word_1 <= '0;
            word_2 <= '0;
            word_3 <= '0;
        end else if (accept) begin
            word_0 <= bus.in_1;
            word_1 <= bus.in_2;
            word_2 <= bus.in_3;
            word_3 <= bus.in_4;
        end
    end

    register_32_4_unloader_word_select_4 #(
        .WIDTH (WIDTH)
    ) u_word_select_4 (
        .word_0 (word_0),
        .word_1 (word_1),
        .word_2 (word_2),
        .word_3 (word_3),
        .index  (index_q),
        .valid  (out_valid_q),
        .data   (out_data)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_index = index_q;
    assign bus.out_last  = last_q;
    assign bus.out_data  = out_data;

endmodule : register_32_4_unloader

// File: tb/tb_register_32_4_unloader.sv
// Directed plus randomized bench; expected outputs come from a queue-of-pending-words model.
module tb_register_32_4_unloader;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Model: words still to be emitted (front is current), and whether in_ready is enabled after reset.
    logic [31:0] pend[$];
    bit          rdy_en;

    register_32_4_unloader_if #(.WIDTH(32)) bus ();

    register_32_4_unloader #(.WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_data;
        logic [31:0] e_idx;
        logic        e_vld;
        e_vld  = (pend.size() > 0);
        e_data = 32'h0;
        e_idx  = 32'h0;
        if (e_vld) begin
            e_data = pend[0];
            e_idx  = 32'(4 - pend.size());
        end
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'(e_vld));
        check({tag, "_busy"},      32'(bus.busy),      32'(e_vld));
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'(!e_vld && rdy_en));
        check({tag, "_out_data"},  bus.out_data,       e_data);
        check({tag, "_out_index"}, 32'(bus.out_index), e_idx);
        check({tag, "_out_last"},  32'(bus.out_last),  32'(pend.size() == 1));
    endtask

    // Advance one clock; model transition uses the values present just before the edge.
    task automatic tick(input string tag);
        bit          acc;
        bit          take;
        logic [31:0] w0, w1, w2, w3;
        acc  = !rst && rdy_en && (pend.size() == 0) && bus.in_valid;
        take = !rst && (pend.size() > 0) && bus.out_ready;
        w0 = bus.in_1; w1 = bus.in_2; w2 = bus.in_3; w3 = bus.in_4;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            rdy_en = 1'b0;
        end else begin
            if (acc) begin
                pend.push_back(w0); pend.push_back(w1);
                pend.push_back(w2); pend.push_back(w3);
            end else if (take) begin
                void'(pend.pop_front());
            end
            rdy_en = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    // Reset raised between edges must clear outputs without any clock.
    task automatic async_reset_pulse(input string tag);
        #3;
        rst = 1'b1;
        pend.delete();
        rdy_en = 1'b0;
        #1;
        check_all({tag, "_async"});
        tick({tag, "_held"});
        rst = 1'b0;
    endtask

    task automatic set_words(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        bus.in_1 = a; bus.in_2 = b; bus.in_3 = c; bus.in_4 = d;
    endtask

    initial begin
        logic [31:0] exp_basic [4];
        checks = 0;
        errors = 0;
        rdy_en = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_words(32'h0, 32'h0, 32'h0, 32'h0);

        // Reset state
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        tick("post_reset");
        check("post_reset_in_ready_is_1", 32'(bus.in_ready), 32'h1);

        // Basic frame with explicit expected words
        exp_basic[0] = 32'h11111111; exp_basic[1] = 32'h22222222;
        exp_basic[2] = 32'h33333333; exp_basic[3] = 32'h44444444;
        set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick("basic_accept");
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("basic_word", bus.out_data, exp_basic[i]);
            check("basic_index", 32'(bus.out_index), 32'(i));
            check("basic_last", 32'(bus.out_last), 32'(i == 3));
            tick("basic_take");
        end
        check("basic_in_ready_cycle5", 32'(bus.in_ready), 32'h1);

        // Backpressure at index 1
        bus.in_valid = 1'b1;
        tick("bp_accept");
        bus.in_valid = 1'b0;
        tick("bp_take0");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("bp_stall");
            check("bp_hold_data", bus.out_data, 32'h22222222);
            check("bp_hold_index", 32'(bus.out_index), 32'h1);
        end
        bus.out_ready = 1'b1;
        tick("bp_resume");
        check("bp_resume_data", bus.out_data, 32'h33333333);
        tick("bp_drain0");
        tick("bp_drain1");

        // Input isolation and back-to-back frames
        bus.in_valid = 1'b1;
        tick("iso_accept");
        set_words(32'hA, 32'hB, 32'hC, 32'hD);
        for (int i = 0; i < 4; i++) tick("iso_send");
        tick("iso_accept2");
        check("iso_second_frame_w0", bus.out_data, 32'hA);
        for (int i = 0; i < 4; i++) tick("iso_send2");
        bus.in_valid = 1'b0;
        tick("iso_idle");

        // Reset mid-frame at index 2
        set_words(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        bus.in_valid = 1'b1;
        tick("mid_accept");
        bus.in_valid = 1'b0;
        tick("mid_take0");
        tick("mid_take1");
        check("mid_index_before_reset", 32'(bus.out_index), 32'h2);
        async_reset_pulse("mid");
        set_words(32'h5, 32'h6, 32'h7, 32'h8);
        bus.in_valid = 1'b1;
        tick("mid_release");
        tick("mid_new_accept");
        bus.in_valid = 1'b0;
        check("mid_new_w0", bus.out_data, 32'h5);
        check("mid_new_idx0", 32'(bus.out_index), 32'h0);
        for (int i = 0; i < 4; i++) tick("mid_new_send");

        // No spurious handshake
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick("quiet");

        // Randomized traffic with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            set_words($urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 59) == 0) begin
                async_reset_pulse("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_32_4_unloader
